// File: rtl/alu_wide_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg / alu_wide_seq_if
// Description : ALU operation/status types and the request/response bundle
//               between decode/execute and the wide-operand sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_status_t;
endpackage

interface alu_wide_seq_if #(
    parameter int WORDS = 2
);
    import alu_pkg::*;
    localparam int WIDTH = 32 * WORDS;

    logic               req_valid;
    logic               req_ready;
    alu_op_e            req_op;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [WIDTH-1:0]   rsp_result;
    alu_status_t        rsp_status;
    logic               rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_status, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_status, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_wide_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_wide_seq
// Description : Issues one WIDTH-bit ADD/SUB to a 32-bit alu one word per
//               cycle, LSW first, chaining carry; returns result and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    alu_wide_seq_if.slave       bus,
    output logic                alu_oe,
    output alu_op_e             alu_operation,
    output logic                alu_carry_in,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  wire logic [31:0]    alu_out,
    input  alu_status_t         alu_status
);
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    alu_op_e                    op_q, op_d;
    logic [WORDS-1:0][31:0]     a_q, a_d;
    logic [WORDS-1:0][31:0]     b_q, b_d;
    logic [WORDS-1:0][31:0]     result_q, result_d;
    logic [KW-1:0]              k_q, k_d;
    logic                       carry_q, carry_d;
    logic                       zacc_q, zacc_d;
    alu_status_t                status_q, status_d;
    logic                       err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            status_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            status_q <= status_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        result_d      = result_q;
        k_d           = k_q;
        carry_d       = carry_q;
        zacc_d        = zacc_q;
        status_d      = status_q;
        err_d         = err_q;
        alu_oe        = 1'b0;
        alu_operation = ALU_ADD;
        alu_carry_in  = 1'b0;
        alu_a         = '0;
        alu_b         = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    a_d      = bus.req_a;
                    b_d      = bus.req_b;
                    k_d      = '0;
                    carry_d  = 1'b0;
                    zacc_d   = 1'b1;
                    result_d = '0;
                    status_d = '0;
                    if (bus.req_op == ALU_ADD || bus.req_op == ALU_SUB) begin
                        err_d   = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                alu_oe        = 1'b1;
                alu_operation = op_q;
                alu_a         = a_q[k_q];
                alu_b         = b_q[k_q];
                alu_carry_in  = carry_q;
                result_d[k_q] = alu_out;
                carry_d       = alu_status.c;
                zacc_d        = zacc_q & alu_status.z;
                // N, C, V come from the top word only; Z is the AND of all words
                if (k_q == K_LAST) begin
                    status_d.n = alu_status.n;
                    status_d.z = zacc_q & alu_status.z;
                    status_d.c = alu_status.c;
                    status_d.v = alu_status.v;
                    state_d    = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = (state_q == S_DONE);
    assign bus.rsp_result = result_q;
    assign bus.rsp_status = status_q;
    assign bus.rsp_err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wide_seq
// Description : Bench for alu_wide_seq (WORDS=2) with a behavioural 32-bit alu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wide_seq;
    import alu_pkg::*;

    localparam int WORDS = 2;
    localparam int W     = 32 * WORDS;

    typedef struct {
        alu_op_e        op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   res;
        logic [3:0]     st;
        logic           err;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           alu_oe;
    alu_op_e        alu_operation;
    logic           alu_carry_in;
    logic [31:0]    alu_a;
    logic [31:0]    alu_b;
    logic [31:0]    alu_out;
    alu_status_t    alu_status;

    alu_wide_seq_if #(.WORDS(WORDS)) bus ();

    alu_wide_seq #(.WORDS(WORDS)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .alu_oe        (alu_oe),
        .alu_operation (alu_operation),
        .alu_carry_in  (alu_carry_in),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_out       (alu_out),
        .alu_status    (alu_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 32-bit alu answering combinationally
    logic [32:0] alu_t;
    logic        alu_v;
    always_comb begin
        alu_t = '0;
        alu_v = 1'b0;
        case (alu_operation)
            ALU_ADD: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b} + 33'(alu_carry_in);
                alu_v = (alu_a[31] == alu_b[31]) && (alu_t[31] != alu_a[31]);
            end
            ALU_SUB: begin
                alu_t = {1'b0, alu_a} - {1'b0, alu_b} - 33'(alu_carry_in);
                alu_v = (alu_a[31] != alu_b[31]) && (alu_t[31] != alu_a[31]);
            end
            default: ;
        endcase
        alu_out      = alu_t[31:0];
        alu_status.n = alu_t[31];
        alu_status.z = (alu_t[31:0] == 32'd0);
        alu_status.c = alu_t[32];
        alu_status.v = alu_v;
    end

    int   total = 0;
    int   bad   = 0;
    int   oe_cnt = 0;
    int   idle_drv_err = 0;
    logic cin_q[$];
    vec_t exp_q[$];
    vec_t tbl[12];

    always @(negedge clk) begin
        if (alu_oe) begin
            oe_cnt++;
            cin_q.push_back(alu_carry_in);
        end else if (alu_a != 32'd0 || alu_b != 32'd0 || alu_carry_in) begin
            idle_drv_err++;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Whole-width reference, independent of the per-word chaining
    function automatic vec_t model(alu_op_e op, logic [W-1:0] a, logic [W-1:0] b);
        vec_t       r;
        logic [W:0] t;
        logic       v;
        r.op = op; r.a = a; r.b = b; r.err = 1'b0;
        t = '0; v = 1'b0;
        if (op == ALU_ADD) begin
            t = {1'b0, a} + {1'b0, b};
            v = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        end else if (op == ALU_SUB) begin
            t = {1'b0, a} - {1'b0, b};
            v = (a[W-1] != b[W-1]) && (t[W-1] != a[W-1]);
        end else begin
            r.res = '0; r.st = 4'b0000; r.err = 1'b1;
            return r;
        end
        r.res = t[W-1:0];
        r.st  = {t[W-1], (t[W-1:0] == '0), t[W], v};
        return r;
    endfunction

    function automatic logic word0_carry(vec_t v);
        logic [32:0] s;
        if (v.op == ALU_ADD) s = {1'b0, v.a[31:0]} + {1'b0, v.b[31:0]};
        else                 s = {1'b0, v.a[31:0]} - {1'b0, v.b[31:0]};
        return s[32];
    endfunction

    task automatic run_vec(input vec_t v, input int hold);
        int          n;
        int          lat;
        int          oe0;
        int          cq0;
        logic [W-1:0] r0;
        logic [3:0]  s0;
        vec_t        e;
        exp_q.push_back(v);
        oe0 = oe_cnt;
        cq0 = cin_q.size();
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", W'(bus.req_ready), W'(1));
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = ALU_ADD;
        bus.req_a     = '0;
        bus.req_b     = '0;
        lat = 1;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 20) begin
            lat++;
            @(negedge clk);
        end
        check("latency", W'(lat), v.err ? W'(1) : W'(WORDS + 1));
        r0 = bus.rsp_result;
        s0 = bus.rsp_status;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable",
                  W'({bus.rsp_valid, bus.req_ready, alu_oe,
                      bus.rsp_result != r0, bus.rsp_status != s0}),
                  W'(5'b10000));
        end
        e = exp_q.pop_front();
        check("result", bus.rsp_result, e.res);
        check("status", W'(bus.rsp_status), W'(e.st));
        check("err",    W'(bus.rsp_err), W'(e.err));
        check("alu_oe_cycles", W'(oe_cnt - oe0), e.err ? W'(0) : W'(WORDS));
        if (!e.err && (cin_q.size() - cq0) == WORDS) begin
            check("carry_in_w0", W'(cin_q[cq0]), W'(0));
            check("carry_in_w1", W'(cin_q[cq0 + 1]), W'(word0_carry(e)));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("rsp_drop", W'({bus.rsp_valid, bus.req_ready}), W'(2'b01));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{ALU_ADD, 64'h0000_0000_ffff_ffff, 64'h1, 64'h0000_0001_0000_0000, 4'b0000, 1'b0};
        tbl[1] = '{ALU_ADD, 64'h7fff_ffff_ffff_ffff, 64'h1, 64'h8000_0000_0000_0000, 4'b1001, 1'b0};
        tbl[2] = '{ALU_ADD, 64'hffff_ffff_ffff_ffff, 64'h2, 64'h1, 4'b0010, 1'b0};
        tbl[3] = '{ALU_SUB, 64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0, 64'h0, 4'b0100, 1'b0};
        tbl[4] = '{ALU_SUB, 64'h0, 64'h1, 64'hffff_ffff_ffff_ffff, 4'b1010, 1'b0};
        tbl[5] = '{ALU_XOR, 64'hdead_beef_0000_0001, 64'h5, 64'h0, 4'b0000, 1'b1};
        tbl[6] = '{ALU_SUB, 64'h8000_0000_0000_0000, 64'h1, 64'h7fff_ffff_ffff_ffff, 4'b0001, 1'b0};
        for (int i = 7; i < 12; i++) begin
            tbl[i] = model(($urandom_range(0, 1) == 1) ? ALU_SUB : ALU_ADD,
                           {$urandom, $urandom}, {$urandom, $urandom});
        end

        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = ALU_ADD;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", W'({bus.req_ready, bus.rsp_valid, bus.rsp_err, alu_oe, alu_carry_in}),
              W'(5'b10000));
        check("reset_result", bus.rsp_result, '0);
        check("reset_status", W'(bus.rsp_status), W'(0));
        check("reset_alu_ab", {alu_a, alu_b}, '0);

        for (int i = 0; i < 12; i++) begin
            run_vec(tbl[i], (i == 1) ? 5 : (i % 3));
        end

        // Reset while the first word is on the alu; the op must be dropped
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = ALU_ADD;
        bus.req_a     = tbl[0].a;
        bus.req_b     = tbl[0].b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("run_before_rst", W'(alu_oe), W'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("after_rst", W'({bus.req_ready, bus.rsp_valid, alu_oe}), W'(3'b100));
        run_vec(tbl[2], 0);
        run_vec(model(ALU_ADD, 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210), 1);

        check("idle_alu_drive", W'(idle_drv_err), W'(0));
        check("scoreboard_empty", W'(exp_q.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
